// File: rtl/storage_controller.sv
// ----------------------------------------------------------------------------
// storage_controller
//
// Purpose:
//   Memory-side controller that sits between the CPU load/store port and the
//   backing storage. Word addresses below 0x800 go to a 2048 x 32 internal
//   SRAM. Reads at or above 0x800 become SPI READ (0x03) transactions to an
//   external flash. In programming mode the flash pins are handed straight
//   to an off-chip programmer.
//
// Ports:
//   clk, rst                     system clock, async active-high reset
//   memory_access                request valid, held until the access completes
//   memory_is_writing            1 = write, 0 = read
//   addr [31:0]                  word address
//   d_in [31:0], mem_be [3:0]    write data and byte enables
//   d_out [31:0], out_valid      read data and read-complete flag
//   set_programming_mode         1 = SPI passthrough to the programmer
//   external_storage_spi_*       pins to the external flash
//   programming_spi_*            pins from the off-chip programmer
// ----------------------------------------------------------------------------
module storage_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_access,
    input  logic        memory_is_writing,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic [3:0]  mem_be,
    output logic [31:0] d_out,
    output logic        out_valid,
    input  logic        set_programming_mode,
    output logic        external_storage_spi_cs_n,
    output logic        external_storage_spi_sck,
    output logic        external_storage_spi_mosi,
    input  logic        external_storage_spi_miso,
    input  logic        programming_spi_cs_n,
    input  logic        programming_spi_sck,
    input  logic        programming_spi_mosi,
    output logic        programming_spi_miso
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRAM_RD,
        ST_SPI_XFER,
        ST_DONE
    } state_t;

    localparam logic [7:0] SPI_READ_CMD  = 8'h03;
    // 64 SCK periods = 128 half-period steps (command + address + 32 data bits)
    localparam logic [7:0] XFER_LAST_STEP = 8'd127;
    localparam logic [7:0] XFER_END_STEP  = 8'd128;

    state_t      r_state;
    logic [31:0] r_sram [0:2047];
    logic [10:0] r_sram_addr;
    logic [31:0] r_d_out;
    logic        r_out_valid;
    logic [31:0] r_tx;        // remaining outgoing bits, MSB first
    logic [31:0] r_rx;        // last 32 bits seen on miso
    logic [7:0]  r_step;      // half-period counter inside a flash transfer
    logic        r_cs_n;
    logic        r_sck;
    logic        r_mosi;

    logic        w_is_ext;
    logic        w_wr_en;
    logic [31:0] w_tx_word;

    assign w_is_ext  = (addr[31:11] != 21'd0);
    // Writes are only taken from IDLE so a request flipping to write mid-read
    // cannot disturb the SRAM.
    assign w_wr_en   = memory_access && memory_is_writing && !w_is_ext &&
                       (r_state == ST_IDLE);
    assign w_tx_word = {SPI_READ_CMD, addr[21:0], 2'b00};

    // NOTE: the SRAM array has no reset; clearing 2048 words would prevent
    // mapping to a RAM macro and software never relies on its initial value.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    r_sram[addr[10:0]][8*b +: 8] <= d_in[8*b +: 8];
                end
            end
        end
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would let later statements see same-edge updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sram_addr <= 11'd0;
            r_d_out     <= 32'd0;
            r_out_valid <= 1'b0;
            r_tx        <= 32'd0;
            r_rx        <= 32'd0;
            r_step      <= 8'd0;
            r_cs_n      <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (memory_access && !memory_is_writing) begin
                        if (!w_is_ext) begin
                            r_sram_addr <= addr[10:0];
                            r_state     <= ST_SRAM_RD;
                        end else if (!set_programming_mode) begin
                            // First bit goes out with cs_n; the rest wait for
                            // the falling sck edges (mode 0).
                            r_mosi  <= w_tx_word[31];
                            r_tx    <= {w_tx_word[30:0], 1'b0};
                            r_cs_n  <= 1'b0;
                            r_sck   <= 1'b0;
                            r_step  <= 8'd0;
                            r_state <= ST_SPI_XFER;
                        end
                    end
                end

                ST_SRAM_RD: begin
                    r_d_out     <= r_sram[r_sram_addr];
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end

                ST_SPI_XFER: begin
                    if (r_step == XFER_END_STEP) begin
                        // Bytes arrive first-byte-first; byte k lands in lane k.
                        r_d_out     <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_step <= r_step + 8'd1;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[30:0], external_storage_spi_miso};
                        end else begin
                            r_sck  <= 1'b0;
                            r_mosi <= r_tx[31];
                            r_tx   <= {r_tx[30:0], 1'b0};
                            if (r_step == XFER_LAST_STEP) begin
                                r_cs_n <= 1'b1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (!memory_access) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_out     = r_d_out;
    assign out_valid = r_out_valid;

    // Passthrough is purely combinational so the programmer works even while
    // the controller is held in reset or unclocked.
    assign external_storage_spi_cs_n = set_programming_mode ? programming_spi_cs_n : r_cs_n;
    assign external_storage_spi_sck  = set_programming_mode ? programming_spi_sck  : r_sck;
    assign external_storage_spi_mosi = set_programming_mode ? programming_spi_mosi : r_mosi;
    assign programming_spi_miso      = set_programming_mode ? external_storage_spi_miso : 1'b0;

endmodule

// File: tb/tb_storage_controller.sv
// ----------------------------------------------------------------------------
// tb_storage_controller
//
// Purpose:
//   Directed self-checking bench for storage_controller: reset values, SPI
//   passthrough, full SRAM sweep, byte enables, flash read through a small
//   SPI flash model, reset during a transfer, and write-then-read ordering.
// ----------------------------------------------------------------------------
module tb_storage_controller;

    logic        clk;
    logic        rst;
    logic        memory_access;
    logic        memory_is_writing;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [3:0]  mem_be;
    logic [31:0] d_out;
    logic        out_valid;
    logic        set_programming_mode;
    logic        external_storage_spi_cs_n;
    logic        external_storage_spi_sck;
    logic        external_storage_spi_mosi;
    logic        external_storage_spi_miso;
    logic        programming_spi_cs_n;
    logic        programming_spi_sck;
    logic        programming_spi_mosi;
    logic        programming_spi_miso;

    // Flash model state; the miso line comes from the model in normal mode and
    // from the bench directly while checking passthrough.
    logic        flash_miso;
    logic        tb_miso;
    logic [31:0] flash_cmd;
    int          flash_bits;
    logic [31:0] flash_data;

    int n_vec;
    int n_err;

    assign external_storage_spi_miso = set_programming_mode ? tb_miso : flash_miso;

    storage_controller dut (
        .clk                       (clk),
        .rst                       (rst),
        .memory_access             (memory_access),
        .memory_is_writing         (memory_is_writing),
        .addr                      (addr),
        .d_in                      (d_in),
        .mem_be                    (mem_be),
        .d_out                     (d_out),
        .out_valid                 (out_valid),
        .set_programming_mode      (set_programming_mode),
        .external_storage_spi_cs_n (external_storage_spi_cs_n),
        .external_storage_spi_sck  (external_storage_spi_sck),
        .external_storage_spi_mosi (external_storage_spi_mosi),
        .external_storage_spi_miso (external_storage_spi_miso),
        .programming_spi_cs_n      (programming_spi_cs_n),
        .programming_spi_sck       (programming_spi_sck),
        .programming_spi_mosi      (programming_spi_mosi),
        .programming_spi_miso      (programming_spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPI flash, mode 0: captures the first 32 mosi bits, then shifts
    // flash_data out MSB first, changing miso on falling sck.
    always @(negedge external_storage_spi_cs_n) begin
        flash_bits = 0;
        flash_miso = 1'b0;
    end

    always @(posedge external_storage_spi_sck) begin
        if (!external_storage_spi_cs_n) begin
            if (flash_bits < 32) flash_cmd = {flash_cmd[30:0], external_storage_spi_mosi};
            flash_bits = flash_bits + 1;
        end
    end

    always @(negedge external_storage_spi_sck) begin
        if (!external_storage_spi_cs_n && flash_bits >= 32 && flash_bits < 64)
            flash_miso = flash_data[63 - flash_bits];
    end

    task automatic sram_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        memory_access     = 1'b1;
        memory_is_writing = 1'b1;
        addr              = a;
        d_in              = d;
        mem_be            = be;
        @(posedge clk);
        @(negedge clk);
        memory_access     = 1'b0;
        memory_is_writing = 1'b0;
    endtask

    // Read sampled at edge N; result observed just after edge N+1.
    task automatic sram_read(input logic [31:0] a, output logic [31:0] data, output logic valid);
        @(negedge clk);
        memory_access     = 1'b1;
        memory_is_writing = 1'b0;
        addr              = a;
        @(posedge clk);
        @(posedge clk);
        #1;
        data  = d_out;
        valid = out_valid;
        @(negedge clk);
        memory_access = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (d_out !== 32'h0) begin n_err++; $display("FAIL reset_d_out got=%h exp=00000000", d_out); end
        n_vec++; if (external_storage_spi_cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n got=%b exp=1", external_storage_spi_cs_n); end
        n_vec++; if (external_storage_spi_sck !== 1'b0) begin n_err++; $display("FAIL reset_sck got=%b exp=0", external_storage_spi_sck); end
        n_vec++; if (external_storage_spi_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got=%b exp=0", external_storage_spi_mosi); end
        n_vec++; if (programming_spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_prog_miso got=%b exp=0", programming_spi_miso); end
    endtask

    task automatic test_passthrough;
        logic [2:0]  pins;
        logic [31:0] data;
        logic        valid;
        set_programming_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pins = i[2:0];
            programming_spi_mosi = pins[2];
            programming_spi_sck  = pins[1];
            programming_spi_cs_n = pins[0];
            #1;
            n_vec++; if ({external_storage_spi_mosi, external_storage_spi_sck, external_storage_spi_cs_n} !== pins) begin
                n_err++; $display("FAIL pt_pins got=%b exp=%b", {external_storage_spi_mosi, external_storage_spi_sck, external_storage_spi_cs_n}, pins);
            end
        end
        tb_miso = 1'b0; #1;
        n_vec++; if (programming_spi_miso !== 1'b0) begin n_err++; $display("FAIL pt_miso0 got=%b exp=0", programming_spi_miso); end
        tb_miso = 1'b1; #1;
        n_vec++; if (programming_spi_miso !== 1'b1) begin n_err++; $display("FAIL pt_miso1 got=%b exp=1", programming_spi_miso); end

        // External read is not served while the programmer owns the bus.
        programming_spi_cs_n = 1'b1;
        programming_spi_sck  = 1'b0;
        programming_spi_mosi = 1'b0;
        @(negedge clk);
        memory_access     = 1'b1;
        memory_is_writing = 1'b0;
        addr              = 32'h0000_0900;
        repeat (6) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pt_ext_read_valid got=%b exp=0", out_valid); end
        n_vec++; if (external_storage_spi_cs_n !== 1'b1) begin n_err++; $display("FAIL pt_ext_read_cs_n got=%b exp=1", external_storage_spi_cs_n); end
        @(negedge clk);
        memory_access = 1'b0;
        @(posedge clk);

        // SRAM still works in programming mode.
        sram_write(32'h3, 32'hA5A5_0003, 4'hF);
        sram_read(32'h3, data, valid);
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL pt_sram_valid got=%b exp=1", valid); end
        n_vec++; if (data !== 32'hA5A5_0003) begin n_err++; $display("FAIL pt_sram_data got=%h exp=a5a50003", data); end

        set_programming_mode = 1'b0;
        tb_miso = 1'b0;
        #1;
        n_vec++; if (programming_spi_miso !== 1'b0) begin n_err++; $display("FAIL normal_prog_miso got=%b exp=0", programming_spi_miso); end
        n_vec++; if ({external_storage_spi_mosi, external_storage_spi_sck, external_storage_spi_cs_n} !== 3'b001) begin
            n_err++; $display("FAIL normal_idle_pins got=%b exp=001", {external_storage_spi_mosi, external_storage_spi_sck, external_storage_spi_cs_n});
        end
    endtask

    task automatic test_sram_sweep;
        logic [31:0] data;
        logic        valid;
        for (int i = 0; i < 2048; i++) begin
            sram_write(i, i, 4'hF);
            sram_read(i, data, valid);
            n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid addr=%0h got=%b exp=1", i, valid); end
            n_vec++; if (data !== i) begin n_err++; $display("FAIL sweep_data addr=%0h got=%h exp=%h", i, data, i); end
        end
    endtask

    task automatic test_byte_enables;
        logic [31:0] data;
        logic        valid;
        sram_write(32'h5, 32'hFFFF_FFFF, 4'hF);
        sram_write(32'h5, 32'h0000_0000, 4'b0101);
        sram_read(32'h5, data, valid);
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL be_valid got=%b exp=1", valid); end
        n_vec++; if (data !== 32'hFF00_FF00) begin n_err++; $display("FAIL be_data got=%h exp=ff00ff00", data); end
    endtask

    task automatic test_flash_read;
        int   cycles;
        logic got;
        flash_data = 32'h1122_3344;   // bytes 0x11, 0x22, 0x33, 0x44 in order
        flash_cmd  = 32'h0;
        @(negedge clk);
        memory_access     = 1'b1;
        memory_is_writing = 1'b0;
        addr              = 32'h0000_0800;
        cycles = 0;
        got    = 1'b0;
        while (cycles < 300 && !got) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) begin
                n_vec++; if (external_storage_spi_cs_n !== 1'b0) begin n_err++; $display("FAIL flash_cs_fall got=%b exp=0", external_storage_spi_cs_n); end
            end
            if (out_valid === 1'b1) got = 1'b1;
        end
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL flash_timeout got=%b exp=1", got); end
        n_vec++; if (cycles !== 130) begin n_err++; $display("FAIL flash_latency got=%0d exp=130", cycles); end
        n_vec++; if (d_out !== 32'h4433_2211) begin n_err++; $display("FAIL flash_data got=%h exp=44332211", d_out); end
        n_vec++; if (flash_cmd !== 32'h0300_2000) begin n_err++; $display("FAIL flash_cmd got=%h exp=03002000", flash_cmd); end
        n_vec++; if (external_storage_spi_cs_n !== 1'b1) begin n_err++; $display("FAIL flash_cs_rise got=%b exp=1", external_storage_spi_cs_n); end
        // out_valid holds while the request is held.
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flash_valid_hold got=%b exp=1", out_valid); end
        @(negedge clk);
        memory_access = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flash_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_transfer;
        logic [31:0] data;
        logic        valid;
        @(negedge clk);
        memory_access     = 1'b1;
        memory_is_writing = 1'b0;
        addr              = 32'h0000_0800;
        repeat (30) @(posedge clk);
        #1;
        n_vec++; if (external_storage_spi_cs_n !== 1'b0) begin n_err++; $display("FAIL mid_cs_active got=%b exp=0", external_storage_spi_cs_n); end
        #1;
        rst = 1'b1;
        #1;
        n_vec++; if (external_storage_spi_cs_n !== 1'b1) begin n_err++; $display("FAIL mid_rst_cs_n got=%b exp=1", external_storage_spi_cs_n); end
        n_vec++; if (external_storage_spi_sck !== 1'b0) begin n_err++; $display("FAIL mid_rst_sck got=%b exp=0", external_storage_spi_sck); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        memory_access = 1'b0;
        rst           = 1'b0;
        sram_read(32'h5, data, valid);
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid got=%b exp=1", valid); end
        n_vec++; if (data !== 32'hFF00_FF00) begin n_err++; $display("FAIL post_rst_data got=%h exp=ff00ff00", data); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] data;
        logic        valid;
        sram_write(32'hA, 32'hDEAD_BEEF, 4'hF);
        sram_read(32'hA, data, valid);
        n_vec++; if (data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_data got=%h exp=deadbeef", data); end
        // A write to the external region aliasing word 0xA must be dropped.
        sram_write(32'h0000_080A, 32'h1234_5678, 4'hF);
        sram_read(32'hA, data, valid);
        n_vec++; if (data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ext_write_ignored got=%h exp=deadbeef", data); end
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ext_write_valid got=%b exp=1", valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                  = 1'b1;
        memory_access        = 1'b0;
        memory_is_writing    = 1'b0;
        addr                 = 32'h0;
        d_in                 = 32'h0;
        mem_be               = 4'h0;
        set_programming_mode = 1'b0;
        programming_spi_cs_n = 1'b1;
        programming_spi_sck  = 1'b0;
        programming_spi_mosi = 1'b0;
        tb_miso              = 1'b0;
        flash_miso           = 1'b0;
        flash_cmd            = 32'h0;
        flash_bits           = 0;
        flash_data           = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst = 1'b0;

        test_passthrough;
        test_sram_sweep;
        test_byte_enables;
        test_flash_read;
        test_reset_mid_transfer;
        test_back_to_back;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
